muldiv_ctrl: RTL and testbench

- Iterative RV32M multiply/divide unit with its sequencing controller, attached beside the R-type ALU in the RV32I single-cycle core.
- The decoder raises `req_valid` when an R-type instruction has funct7 = 0000001.
- The block stalls the core while it performs 32 radix-2 iterations, then returns the result on the R-type write-back path for one cycle.
- It handles the RISC-V divide-by-zero and signed-overflow special cases with a 1-cycle fast path.

---
 rtl/muldiv_ctrl_pkg.sv | 30 +++
 rtl/muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_ctrl_step.sv | 27 ++
 rtl/muldiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - RV32M multiply/divide op codes, FSM states and result constants.
package muldiv_ctrl_pkg;

   localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
   localparam logic [31:0] DIV_ZERO_Q    = 32'hFFFF_FFFF;
   localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } muldiv_state_t;

   function automatic logic op_is_div(input muldiv_op op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - decoder/write-back handshake between the core and the muldiv unit.
interface muldiv_ctrl_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rv1;
   logic [XLEN-1:0] rv2;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            resp_valid;
   logic [XLEN-1:0] result;

   modport master (
      output req_valid, funct3, rv1, rv2, flush,
      input  stall, busy, resp_valid, result
   );

   modport slave (
      input  req_valid, funct3, rv1, rv2, flush,
      output stall, busy, resp_valid, result
   );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// rtl/muldiv_ctrl_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   operand_i,
   input  logic              is_div_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic              q_bit_o
);
   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;

   // Restoring keeps rem < divisor, so rem_sh - divisor fits XLEN bits when it is taken.
   always_comb begin
      sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      rem_sh  = acc_i[2*XLEN-1:XLEN-1];
      diff    = rem_sh[XLEN-1:0] - operand_i;
      q_bit_o = 1'b0;
      acc_o   = {sum, acc_i[XLEN-1:1]};
      if (is_div_i) begin
         q_bit_o = (rem_sh >= {1'b0, operand_i});
         acc_o   = {(q_bit_o ? diff : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative RV32M unit: FSM, operand capture, iteration counter and sign fixup.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_ctrl_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   muldiv_state_t   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   muldiv_op        op_q, op_d;
   logic            neg_a_q, neg_a_d;
   logic            neg_b_q, neg_b_d;
   logic [XLEN-1:0] result_q, result_d;

   muldiv_op          req_op;
   logic              a_signed, b_signed, req_neg_a, req_neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;
   logic [2*XLEN-1:0] step_acc;
   logic              step_q_bit;
   logic              sign_diff;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   quot, rem, fixup_res;

   assign req_op    = muldiv_op'(bus.funct3);
   assign a_signed  = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                      (req_op == OP_DIV)  || (req_op == OP_REM);
   assign b_signed  = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
   assign req_neg_a = a_signed & bus.rv1[XLEN-1];
   assign req_neg_b = b_signed & bus.rv2[XLEN-1];
   assign mag_a     = req_neg_a ? ('0 - bus.rv1) : bus.rv1;
   assign mag_b     = req_neg_b ? ('0 - bus.rv2) : bus.rv2;

   assign div_zero    = op_is_div(req_op) && (bus.rv2 == '0);
   assign div_ovf     = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                        (bus.rv1 == DIV_OVF_Q) && (bus.rv2 == '1);
   assign special     = div_zero || div_ovf;
   assign special_res = div_zero ? (req_op[1] ? bus.rv1 : DIV_ZERO_Q)
                                 : (req_op[1] ? '0 : DIV_OVF_Q);

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .is_div_i  (op_is_div(op_q)),
      .acc_o     (step_acc),
      .q_bit_o   (step_q_bit)
   );

   assign sign_diff = neg_a_q ^ neg_b_q;
   assign product   = sign_diff ? ('0 - acc_q) : acc_q;
   assign quot      = sign_diff ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
   assign rem       = neg_a_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fixup_res = '0;
      unique case (op_q)
         OP_MUL:                      fixup_res = product[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fixup_res = product[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             fixup_res = quot;
         OP_REM, OP_REMU:             fixup_res = rem;
         default:                     fixup_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (special) begin
                  result_d = special_res;
                  state_d  = DONE;
               end else begin
                  op_d    = req_op;
                  acc_d   = {{XLEN{1'b0}}, mag_a};
                  opnd_d  = mag_b;
                  neg_a_d = req_neg_a;
                  neg_b_d = req_neg_b;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = step_acc | {{(2*XLEN-1){1'b0}}, step_q_bit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) state_d = FIXUP;
         end
         FIXUP: begin
            result_d = fixup_res;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A flush must not leave a half-loaded result behind either.
      if (bus.flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_q     <= OP_MUL;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         result_q <= result_d;
      end
   end

   assign bus.resp_valid = (state_q == DONE) && !bus.flush;
   assign bus.stall      = bus.req_valid & ~bus.resp_valid;
   assign bus.busy       = (state_q != IDLE);
   assign bus.result     = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   muldiv_ctrl_if #(.XLEN(32)) bus ();

   muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      int          ia, ib;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      ia = a;
      ib = b;
      p  = '0;
      case (f3)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
      logic [31:0] exp;
      int          lat_exp, lat;
      exp     = ref_result(f3, a, b);
      lat_exp = is_special(f3, a, b) ? 1 : 34;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.funct3    = f3;
      bus.rv1       = a;
      bus.rv2       = b;
      #1;
      check({tag, " stall c0"}, 32'(bus.stall), 32'd1);
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            lat = n;
            break;
         end
         check({tag, " stall"}, 32'(bus.stall), 32'd1);
         if (scramble) begin
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.rv1    = $urandom;
            bus.rv2    = $urandom;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(lat_exp));
      check({tag, " result"}, bus.result, exp);
      check({tag, " stall at resp"}, 32'(bus.stall), 32'd0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check({tag, " busy after"}, 32'(bus.busy), 32'd0);
      check({tag, " result hold"}, bus.result, exp);
   endtask

   task automatic count_resp(input int cycles, output int hits);
      hits = 0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         if (bus.resp_valid) hits++;
      end
   endtask

   initial begin
      int hits;
      logic [2:0]  rf3;
      logic [31:0] ra, rb;
      bus.req_valid = 1'b0;
      bus.funct3    = 3'd0;
      bus.rv1       = '0;
      bus.rv2       = '0;
      bus.flush     = 1'b0;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      check("reset result", bus.result, 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
      check("reset stall", 32'(bus.stall), 32'd0);
      reset = 1'b0;

      run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
      check("MUL model", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      run_op("MULH min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      run_op("MULHSU -1*ffffffff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      run_op("MULHU ffffffff^2", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 1'b1);
      run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 1'b1);
      run_op("DIVU 100/0", 3'd5, 32'd100, 32'd0, 1'b0);
      run_op("REMU 100/0", 3'd7, 32'd100, 32'd0, 1'b0);
      run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

      // flush while DONE gates that cycle's response
      @(negedge clk);
      bus.req_valid = 1'b1; bus.funct3 = 3'd5; bus.rv1 = 32'd5; bus.rv2 = 32'd0;
      @(negedge clk);
      bus.flush = 1'b1;
      #1;
      check("flush DONE resp", 32'(bus.resp_valid), 32'd0);
      check("flush DONE busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.flush = 1'b0; bus.req_valid = 1'b0;
      check("flush DONE after busy", 32'(bus.busy), 32'd0);

      // flush beats a request in IDLE
      @(negedge clk);
      bus.req_valid = 1'b1; bus.funct3 = 3'd0; bus.rv1 = 32'd3; bus.rv2 = 32'd3; bus.flush = 1'b1;
      @(negedge clk);
      check("flush IDLE busy", 32'(bus.busy), 32'd0);
      bus.flush = 1'b0; bus.req_valid = 1'b0;

      // flush in CALC at cycle 10
      @(negedge clk);
      bus.req_valid = 1'b1; bus.funct3 = 3'd4; bus.rv1 = 32'd1000; bus.rv2 = 32'd3;
      hits = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (bus.resp_valid) hits++;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush CALC busy", 32'(bus.busy), 32'd0);
      check("flush CALC resp", 32'(bus.resp_valid), 32'd0);
      bus.flush = 1'b0; bus.req_valid = 1'b0;
      count_resp(40, hits);
      check("flush CALC no resp", 32'(hits), 32'd0);

      // reset in CALC at cycle 20
      @(negedge clk);
      bus.req_valid = 1'b1; bus.funct3 = 3'd4; bus.rv1 = 32'd1000; bus.rv2 = 32'd3;
      repeat (20) @(negedge clk);
      reset = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      check("reset CALC result", bus.result, 32'd0);
      check("reset CALC busy", 32'(bus.busy), 32'd0);
      reset = 1'b0; bus.flush = 1'b0; bus.req_valid = 1'b0;
      count_resp(40, hits);
      check("reset CALC no resp", 32'(hits), 32'd0);

      run_op("DIV 1000/3", 3'd4, 32'd1000, 32'd3, 1'b0);
      check("DIV 1000/3 model", ref_result(3'd4, 32'd1000, 32'd3), 32'd333);

      run_op("b2b MUL 3*5", 3'd0, 32'd3, 32'd5, 1'b1);
      run_op("b2b MUL 6*7", 3'd0, 32'd6, 32'd7, 1'b1);

      for (int i = 0; i < 30; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 20));
            3: ra = {1'b1, 31'($urandom_range(0, 100))};
            default: ;
         endcase
         run_op($sformatf("rand%0d op%0d", i, rf3), rf3, ra, rb, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
